// File: rtl/id_ex_stage_if.sv
// Handshake, operand and forwarding bundle between decode, the ID/EX stage and the ALU side.
// "slave" is the stage's view; "master" is the driving environment's view.
interface id_ex_stage_if #(
    parameter int XLEN = 64,
    parameter int REGW = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;
    logic [REGW-1:0] in_rs1;
    logic [REGW-1:0] in_rs2;
    logic [REGW-1:0] in_rd;
    logic            in_alu_src;
    logic [3:0]      in_alu_op;
    logic            in_reg_write;
    logic            flush;
    logic            out_ready;
    logic            exmem_reg_write;
    logic [REGW-1:0] exmem_rd;
    logic [XLEN-1:0] exmem_result;
    logic            memwb_reg_write;
    logic [REGW-1:0] memwb_rd;
    logic [XLEN-1:0] memwb_result;
    logic            out_valid;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [3:0]      OP;
    logic [XLEN-1:0] out_store_data;
    logic [REGW-1:0] out_rd;
    logic            out_reg_write;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;

    modport slave (
        input  in_valid, in_rs1_data, in_rs2_data, in_imm, in_rs1, in_rs2, in_rd,
               in_alu_src, in_alu_op, in_reg_write, flush, out_ready,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output in_ready, out_valid, A, B, OP, out_store_data, out_rd, out_reg_write,
               fwd_a, fwd_b
    );

    modport master (
        output in_valid, in_rs1_data, in_rs2_data, in_imm, in_rs1, in_rs2, in_rd,
               in_alu_src, in_alu_op, in_reg_write, flush, out_ready,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  in_ready, out_valid, A, B, OP, out_store_data, out_rd, out_reg_write,
               fwd_a, fwd_b
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX holding register feeding the ALU; operands pass through a combinational
// EX/MEM > MEM/WB > register-file forwarding mux evaluated against the held indices.
module id_ex_stage #(
    parameter int XLEN = 64,
    parameter int REGW = 5
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);

    logic                   vld_p0;
    logic signed [XLEN-1:0] rs1_data_p0;
    logic signed [XLEN-1:0] rs2_data_p0;
    logic signed [XLEN-1:0] imm_p0;
    logic        [REGW-1:0] rs1_p0;
    logic        [REGW-1:0] rs2_p0;
    logic        [REGW-1:0] rd_p0;
    logic                   alu_src_p0;
    logic        [3:0]      alu_op_p0;
    logic                   reg_write_p0;

    logic                   in_ready;
    logic        [1:0]      sel_a;
    logic        [1:0]      sel_b;
    logic signed [XLEN-1:0] opa;
    logic signed [XLEN-1:0] rs2_fwd;

    function automatic logic [1:0] fwd_sel(
        input logic [REGW-1:0] src,
        input logic            ex_we,
        input logic [REGW-1:0] ex_rd,
        input logic            wb_we,
        input logic [REGW-1:0] wb_rd
    );
        if (ex_we && (ex_rd != '0) && (ex_rd == src))
            return 2'b10;
        else if (wb_we && (wb_rd != '0) && (wb_rd == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    function automatic logic signed [XLEN-1:0] fwd_val(
        input logic        [1:0]      sel,
        input logic signed [XLEN-1:0] regval,
        input logic signed [XLEN-1:0] ex_val,
        input logic signed [XLEN-1:0] wb_val
    );
        case (sel)
            2'b10:   return ex_val;
            2'b01:   return wb_val;
            default: return regval;
        endcase
    endfunction

    assign in_ready = !vld_p0 || bus.out_ready;

    // Stage p0: capture on handshake, hold on stall; flush squashes only the control bits
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0       <= 1'b0;
            reg_write_p0 <= 1'b0;
            rs1_data_p0  <= '0;
            rs2_data_p0  <= '0;
            imm_p0       <= '0;
            rs1_p0       <= '0;
            rs2_p0       <= '0;
            rd_p0        <= '0;
            alu_src_p0   <= 1'b0;
            alu_op_p0    <= 4'b0000;
        end else if (bus.flush) begin
            vld_p0       <= 1'b0;
            reg_write_p0 <= 1'b0;
        end else if (bus.in_valid && in_ready) begin
            vld_p0       <= 1'b1;
            reg_write_p0 <= bus.in_reg_write && (bus.in_rd != '0);
            rs1_data_p0  <= bus.in_rs1_data;
            rs2_data_p0  <= bus.in_rs2_data;
            imm_p0       <= bus.in_imm;
            rs1_p0       <= bus.in_rs1;
            rs2_p0       <= bus.in_rs2;
            rd_p0        <= bus.in_rd;
            alu_src_p0   <= bus.in_alu_src;
            alu_op_p0    <= bus.in_alu_op;
        end else if (bus.out_ready) begin
            vld_p0       <= 1'b0;
        end
    end

    // Forwarding mux on the held operands, no register in the path
    always_comb begin
        sel_a   = fwd_sel(rs1_p0, bus.exmem_reg_write, bus.exmem_rd,
                          bus.memwb_reg_write, bus.memwb_rd);
        sel_b   = fwd_sel(rs2_p0, bus.exmem_reg_write, bus.exmem_rd,
                          bus.memwb_reg_write, bus.memwb_rd);
        opa     = fwd_val(sel_a, rs1_data_p0, bus.exmem_result, bus.memwb_result);
        rs2_fwd = fwd_val(sel_b, rs2_data_p0, bus.exmem_result, bus.memwb_result);
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = vld_p0;
    assign bus.A              = opa;
    assign bus.B              = alu_src_p0 ? imm_p0 : rs2_fwd;
    assign bus.OP             = alu_op_p0;
    assign bus.out_store_data = rs2_fwd;
    assign bus.out_rd         = rd_p0;
    assign bus.out_reg_write  = reg_write_p0;
    assign bus.fwd_a          = sel_a;
    assign bus.fwd_b          = sel_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: handshake, stall, flush, x0 handling and forwarding priority.
module tb_id_ex_stage;

    localparam int XLEN = 64;
    localparam int REGW = 5;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(XLEN), .REGW(REGW)) bus ();

    id_ex_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                           input logic src, input logic [3:0] op, input logic we);
        bus.in_valid     = 1'b1;
        bus.in_rs1_data  = d1;
        bus.in_rs2_data  = d2;
        bus.in_imm       = imm;
        bus.in_rs1       = r1;
        bus.in_rs2       = r2;
        bus.in_rd        = rd;
        bus.in_alu_src   = src;
        bus.in_alu_op    = op;
        bus.in_reg_write = we;
    endtask

    task automatic fwd_off();
        bus.exmem_reg_write = 1'b0;
        bus.exmem_rd        = '0;
        bus.exmem_result    = '0;
        bus.memwb_reg_write = 1'b0;
        bus.memwb_rd        = '0;
        bus.memwb_result    = '0;
    endtask

    initial begin
        reset            = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_rs1_data  = '0;
        bus.in_rs2_data  = '0;
        bus.in_imm       = '0;
        bus.in_rs1       = '0;
        bus.in_rs2       = '0;
        bus.in_rd        = '0;
        bus.in_alu_src   = 1'b0;
        bus.in_alu_op    = 4'b0000;
        bus.in_reg_write = 1'b0;
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b1;
        fwd_off();

        // reset state
        tick();
        tick();
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_op", 64'(bus.OP), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_A", bus.A, 64'd0);
        chk("rst_fwd_a", 64'(bus.fwd_a), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // add: 2 + 16
        present(64'd2, 64'd16, 64'd0, 5'd1, 5'd2, 5'd5, 1'b0, 4'b0010, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("add_A", bus.A, 64'd2);
        chk("add_B", bus.B, 64'd16);
        chk("add_OP", 64'(bus.OP), 64'h2);
        chk("add_valid", 64'(bus.out_valid), 64'd1);
        chk("add_rd", 64'(bus.out_rd), 64'd5);
        chk("add_we", 64'(bus.out_reg_write), 64'd1);
        tick();
        chk("drain_valid", 64'(bus.out_valid), 64'd0);

        // immediate select
        present(64'd7, 64'd9, 64'hFFFF_FFFF_FFFF_FFFC, 5'd1, 5'd2, 5'd6, 1'b1, 4'b0010, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("imm_A", bus.A, 64'd7);
        chk("imm_B", bus.B, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("imm_store", bus.out_store_data, 64'd9);

        // forwarding priority on held rs1=3; stall keeps it held
        present(64'd1, 64'd20, 64'd0, 5'd3, 5'd4, 5'd8, 1'b0, 4'b0010, 1'b1);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 64'd100;
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_result = 64'd200;
        #1;
        chk("fwd_ex_A", bus.A, 64'd100);
        chk("fwd_ex_sel", 64'(bus.fwd_a), 64'h2);
        chk("fwd_ex_B", bus.B, 64'd20);
        bus.exmem_reg_write = 1'b0;
        #1;
        chk("fwd_wb_A", bus.A, 64'd200);
        chk("fwd_wb_sel", 64'(bus.fwd_a), 64'h1);
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0; bus.memwb_rd = 5'd0;
        #1;
        chk("fwd_reg_A", bus.A, 64'd1);
        chk("fwd_reg_sel", 64'(bus.fwd_a), 64'h0);
        fwd_off();

        // stall with a pending instruction
        present(64'd11, 64'd22, 64'd0, 5'd6, 5'd7, 5'd9, 1'b0, 4'b0110, 1'b1);
        #1;
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        chk("stall1_A", bus.A, 64'd1);
        chk("stall1_OP", 64'(bus.OP), 64'h2);
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_result = 64'd300;
        #1;
        chk("stall_wb_A", bus.A, 64'd300);
        chk("stall_wb_sel", 64'(bus.fwd_a), 64'h1);
        tick();
        fwd_off();
        #1;
        chk("stall2_B", bus.B, 64'd20);
        chk("stall2_rd", 64'(bus.out_rd), 64'd8);
        tick();
        chk("stall3_A", bus.A, 64'd1);
        chk("stall3_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        #1;
        chk("release_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("release_A", bus.A, 64'd11);
        chk("release_B", bus.B, 64'd22);
        chk("release_OP", 64'(bus.OP), 64'h6);
        chk("release_rd", 64'(bus.out_rd), 64'd9);

        // flush wins over a same-cycle capture
        present(64'd99, 64'd98, 64'd0, 5'd1, 5'd2, 5'd12, 1'b0, 4'b0111, 1'b1);
        bus.flush = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_we", 64'(bus.out_reg_write), 64'd0);
        chk("flush_rd", 64'(bus.out_rd), 64'd9);
        chk("flush_OP", 64'(bus.OP), 64'h6);

        // x0 destination and rd=0 forwarding sources
        present(64'd5, 64'd6, 64'd0, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0010, 1'b1);
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 64'd55;
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd0; bus.memwb_result = 64'd55;
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("x0_valid", 64'(bus.out_valid), 64'd1);
        chk("x0_we", 64'(bus.out_reg_write), 64'd0);
        chk("x0_A", bus.A, 64'd5);
        chk("x0_B", bus.B, 64'd6);
        chk("x0_fwd_b", 64'(bus.fwd_b), 64'h0);
        fwd_off();

        // back-to-back captures
        present(64'd3, 64'd0, 64'd0, 5'd1, 5'd2, 5'd1, 1'b0, 4'b0010, 1'b1);
        tick();
        present(64'd4, 64'd0, 64'd0, 5'd1, 5'd2, 5'd2, 1'b0, 4'b0010, 1'b1);
        #1;
        chk("b2b_in_ready", 64'(bus.in_ready), 64'd1);
        chk("b2b_A0", bus.A, 64'd3);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("b2b_A1", bus.A, 64'd4);
        chk("b2b_valid", 64'(bus.out_valid), 64'd1);

        // reset while stalled discards the held instruction
        bus.out_ready = 1'b0;
        reset = 1'b1;
        tick();
        chk("rst_stall_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_stall_A", bus.A, 64'd0);
        chk("rst_stall_OP", 64'(bus.OP), 64'd0);
        chk("rst_stall_in_ready", 64'(bus.in_ready), 64'd1);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
